// File: rtl/fetch_pred_unit.sv
// Instruction-fetch stage: PC register, instruction pass-through and next-PC
// prediction from a 2-bit-counter BHT combined with a direct-mapped BTB.
module fetch_pred_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int INDEX_BITS    = 6,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_Stall,
    input  logic                     i_Redirect,
    input  logic [ADDRESS_WIDTH-1:0] i_Redirect_PC,
    input  logic                     i_Update,
    input  logic [ADDRESS_WIDTH-1:0] i_Update_PC,
    input  logic                     i_Update_Taken,
    input  logic [ADDRESS_WIDTH-1:0] i_Update_Target,
    output logic [ADDRESS_WIDTH-1:0] o_IMem_Addr,
    input  logic [DATA_WIDTH-1:0]    i_IMem_Data,
    output logic [ADDRESS_WIDTH-1:0] o_PC,
    output logic [DATA_WIDTH-1:0]    o_Instruction,
    output logic                     o_prediction,
    output logic                     o_Flush
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDRESS_WIDTH - INDEX_BITS - 2;

    logic [ADDRESS_WIDTH-1:0] pc_reg;
    logic [ADDRESS_WIDTH-1:0] pc_next;

    logic [1:0]               bht_reg        [ENTRIES];
    logic                     btb_valid_reg  [ENTRIES];
    logic [TAG_BITS-1:0]      btb_tag_reg    [ENTRIES];
    logic [ADDRESS_WIDTH-1:0] btb_target_reg [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  predict_taken;

    assign fetch_idx = pc_reg[INDEX_BITS+1:2];
    assign fetch_tag = pc_reg[ADDRESS_WIDTH-1:INDEX_BITS+2];
    assign upd_idx   = i_Update_PC[INDEX_BITS+1:2];
    assign upd_tag   = i_Update_PC[ADDRESS_WIDTH-1:INDEX_BITS+2];

    // Lookups read the registered tables, so a same-cycle update is not visible yet.
    assign predict_taken = bht_reg[fetch_idx][1]
                         && btb_valid_reg[fetch_idx]
                         && (btb_tag_reg[fetch_idx] == fetch_tag);

    always_comb begin
        pc_next = pc_reg + ADDRESS_WIDTH'(4);
        if (i_Redirect) begin
            pc_next = i_Redirect_PC;
        end else if (i_Stall) begin
            pc_next = pc_reg;
        end else if (predict_taken) begin
            pc_next = btb_target_reg[fetch_idx];
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_reg[i]       <= 2'b01;
                btb_valid_reg[i] <= 1'b0;
            end
        end else if (i_Update) begin
            if (i_Update_Taken) begin
                if (bht_reg[upd_idx] != 2'b11) begin
                    bht_reg[upd_idx] <= bht_reg[upd_idx] + 2'b01;
                end
                btb_valid_reg[upd_idx] <= 1'b1;
            end else if (bht_reg[upd_idx] != 2'b00) begin
                bht_reg[upd_idx] <= bht_reg[upd_idx] - 2'b01;
            end
        end
    end

    // Tag and target payload are qualified by the valid bit, so they need no reset.
    always_ff @(posedge i_Clk) begin
        if (i_Update && i_Update_Taken) begin
            btb_tag_reg[upd_idx]    <= upd_tag;
            btb_target_reg[upd_idx] <= i_Update_Target;
        end
    end

    assign o_IMem_Addr   = pc_reg;
    assign o_PC          = pc_reg;
    assign o_Instruction = i_IMem_Data;
    assign o_prediction  = predict_taken;
    assign o_Flush       = i_Redirect;

endmodule
